// File: rtl/reg_file_sb_if.sv
// Register-file bus: two read ports, write-back port, issue port and scoreboard status.
// The datapath side is the master; the register file is the slave.
interface reg_file_sb_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5
);
    logic [ADDR_W-1:0] readReg1;
    logic [ADDR_W-1:0] readReg2;
    logic [DATA_W-1:0] readData1;
    logic [DATA_W-1:0] readData2;
    logic              regWrite;
    logic [ADDR_W-1:0] writeReg;
    logic [DATA_W-1:0] writeData;
    logic              issue;
    logic [ADDR_W-1:0] issueReg;
    logic              busy1;
    logic              busy2;
    logic              hazard;
    logic              wawIssue;
    logic [ADDR_W:0]   busyCount;

    modport master (
        output readReg1, readReg2, regWrite, writeReg, writeData, issue, issueReg,
        input  readData1, readData2, busy1, busy2, hazard, wawIssue, busyCount
    );

    modport slave (
        input  readReg1, readReg2, regWrite, writeReg, writeData, issue, issueReg,
        output readData1, readData2, busy1, busy2, hazard, wawIssue, busyCount
    );
endinterface

// File: rtl/reg_file_sb.sv
// Two-read/one-write register file with write-to-read bypass and a per-register
// write-back scoreboard that lets decode stall on RAW hazards.
module reg_file_sb #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned ZERO_REG = 1
) (
    input  logic          clk,
    input  logic          rst,
    reg_file_sb_if.slave  bus
);
    localparam int unsigned DEPTH = 1 << ADDR_W;
    localparam bit          ZR    = (ZERO_REG != 0);

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DATA_W-1:0] regs_d [DEPTH];
    logic [DEPTH-1:0]  busy_q, busy_d;
    logic [ADDR_W:0]   busy_count_q, busy_count_d;

    logic write_eff, issue_eff, cnt_inc, cnt_dec;

    // Writes and issues to the hard-wired zero register are dropped outright.
    assign write_eff = bus.regWrite & ~(ZR & (bus.writeReg == '0));
    assign issue_eff = bus.issue    & ~(ZR & (bus.issueReg == '0));

    always_comb begin
        regs_d = regs_q;
        busy_d = busy_q;
        if (write_eff) begin
            regs_d[bus.writeReg] = bus.writeData;
            busy_d[bus.writeReg] = 1'b0;
        end
        // Applied after the clear so a same-register issue (younger producer) wins.
        if (issue_eff) begin
            busy_d[bus.issueReg] = 1'b1;
        end
    end

    always_comb begin
        cnt_inc      = issue_eff & ~busy_q[bus.issueReg];
        cnt_dec      = write_eff & busy_q[bus.writeReg] &
                       ~(issue_eff & (bus.issueReg == bus.writeReg));
        busy_count_d = busy_count_q + {{ADDR_W{1'b0}}, cnt_inc}
                                    - {{ADDR_W{1'b0}}, cnt_dec};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            regs_q       <= '{default: '0};
            busy_q       <= '0;
            busy_count_q <= '0;
        end else begin
            regs_q       <= regs_d;
            busy_q       <= busy_d;
            busy_count_q <= busy_count_d;
        end
    end

    always_comb begin
        bus.readData1 = regs_q[bus.readReg1];
        if (write_eff && (bus.writeReg == bus.readReg1)) begin
            bus.readData1 = bus.writeData;
        end
        if (ZR && (bus.readReg1 == '0)) begin
            bus.readData1 = '0;
        end

        bus.readData2 = regs_q[bus.readReg2];
        if (write_eff && (bus.writeReg == bus.readReg2)) begin
            bus.readData2 = bus.writeData;
        end
        if (ZR && (bus.readReg2 == '0)) begin
            bus.readData2 = '0;
        end
    end

    // A write-back landing this cycle satisfies the read through the bypass.
    assign bus.busy1     = busy_q[bus.readReg1] & ~(bus.regWrite & (bus.writeReg == bus.readReg1));
    assign bus.busy2     = busy_q[bus.readReg2] & ~(bus.regWrite & (bus.writeReg == bus.readReg2));
    assign bus.hazard    = bus.busy1 | bus.busy2;
    assign bus.wawIssue  = issue_eff & busy_q[bus.issueReg];
    assign bus.busyCount = busy_count_q;
endmodule

// File: tb/tb_reg_file_sb.sv
// Randomised and directed checks of reg_file_sb against an array-based reference model.
module tb_reg_file_sb;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int DEPTH  = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    reg_file_sb_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    reg_file_sb #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_REG(1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [DATA_W-1:0] mreg  [DEPTH];
    bit                mbusy [DEPTH];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) begin
            mreg[i]  = '0;
            mbusy[i] = 1'b0;
        end
    endtask

    function automatic logic [31:0] exp_read(input int a);
        if (a == 0) return '0;
        if (bus.regWrite && int'(bus.writeReg) == a) return bus.writeData;
        return mreg[a];
    endfunction

    function automatic logic exp_busy(input int a);
        return (a != 0) && mbusy[a] && !(bus.regWrite && int'(bus.writeReg) == a);
    endfunction

    function automatic logic [31:0] exp_count();
        int c = 0;
        for (int i = 0; i < DEPTH; i++) c += int'(mbusy[i]);
        return c;
    endfunction

    task automatic check_outputs();
        logic b1, b2;
        b1 = exp_busy(int'(bus.readReg1));
        b2 = exp_busy(int'(bus.readReg2));
        check_eq("readData1", bus.readData1, exp_read(int'(bus.readReg1)));
        check_eq("readData2", bus.readData2, exp_read(int'(bus.readReg2)));
        check_eq("busy1", 32'(bus.busy1), 32'(b1));
        check_eq("busy2", 32'(bus.busy2), 32'(b2));
        check_eq("hazard", 32'(bus.hazard), 32'(b1 | b2));
        check_eq("wawIssue", 32'(bus.wawIssue),
                 32'(bus.issue && bus.issueReg != 0 && mbusy[int'(bus.issueReg)]));
        check_eq("busyCount", 32'(bus.busyCount), exp_count());
    endtask

    task automatic settle();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic clock_edge();
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            if (bus.regWrite && bus.writeReg != 0) mreg[int'(bus.writeReg)] = bus.writeData;
            if (bus.regWrite) mbusy[int'(bus.writeReg)] = 1'b0;
            if (bus.issue && bus.issueReg != 0) mbusy[int'(bus.issueReg)] = 1'b1;
        end
        #1;
    endtask

    task automatic cycle();
        settle();
        clock_edge();
    endtask

    task automatic drive(input bit we, input int wa, input logic [31:0] wd,
                         input bit iss, input int ia, input int r1, input int r2);
        bus.regWrite  = we;
        bus.writeReg  = ADDR_W'(wa);
        bus.writeData = wd;
        bus.issue     = iss;
        bus.issueReg  = ADDR_W'(ia);
        bus.readReg1  = ADDR_W'(r1);
        bus.readReg2  = ADDR_W'(r2);
    endtask

    initial begin
        rst = 1'b1;
        model_reset();
        drive(0, 0, '0, 0, 0, 5, 5);
        cycle();
        cycle();
        rst = 1'b0;

        // bypass then stored value
        drive(1, 5, 32'hDEADBEEF, 0, 0, 5, 5);
        settle();
        check_eq("bypass_r5_p1", bus.readData1, 32'hDEADBEEF);
        check_eq("bypass_r5_p2", bus.readData2, 32'hDEADBEEF);
        clock_edge();
        drive(0, 0, '0, 0, 0, 5, 5);
        settle();
        check_eq("stored_r5", bus.readData1, 32'hDEADBEEF);
        clock_edge();

        // zero register
        drive(1, 0, 32'hFFFFFFFF, 0, 0, 0, 0);
        cycle();
        drive(0, 0, '0, 1, 0, 0, 0);
        cycle();
        drive(0, 0, '0, 0, 0, 0, 0);
        settle();
        check_eq("r0_read", bus.readData1, 32'h0);
        check_eq("r0_count", 32'(bus.busyCount), 32'h0);
        check_eq("r0_busy", 32'(bus.busy1), 32'h0);
        clock_edge();

        // RAW on r7
        drive(0, 0, '0, 1, 7, 0, 0);
        cycle();
        drive(0, 0, '0, 0, 0, 7, 0);
        settle();
        check_eq("r7_busy1", 32'(bus.busy1), 32'h1);
        check_eq("r7_hazard", 32'(bus.hazard), 32'h1);
        check_eq("r7_count", 32'(bus.busyCount), 32'h1);
        clock_edge();
        drive(1, 7, 32'h1234, 0, 0, 7, 0);
        settle();
        check_eq("r7_wb_busy1", 32'(bus.busy1), 32'h0);
        check_eq("r7_wb_data", bus.readData1, 32'h1234);
        clock_edge();
        drive(0, 0, '0, 0, 0, 7, 0);
        settle();
        check_eq("r7_wb_count", 32'(bus.busyCount), 32'h0);
        clock_edge();

        // issue + write-back collision on busy r3, WAW on r9
        drive(0, 0, '0, 1, 3, 0, 0);
        cycle();
        drive(0, 0, '0, 1, 9, 0, 0);
        cycle();
        drive(1, 3, 32'h55, 1, 3, 3, 0);
        cycle();
        drive(0, 0, '0, 1, 9, 3, 0);
        settle();
        check_eq("r3_still_busy", 32'(bus.busy1), 32'h1);
        check_eq("r3_count", 32'(bus.busyCount), 32'h2);
        check_eq("r9_waw", 32'(bus.wawIssue), 32'h1);
        clock_edge();
        drive(0, 0, '0, 0, 0, 9, 3);
        settle();
        check_eq("r9_count", 32'(bus.busyCount), 32'h2);
        clock_edge();
        drive(1, 3, 32'hAAAA, 0, 0, 9, 9);
        cycle();
        drive(0, 0, '0, 0, 0, 3, 3);
        settle();
        check_eq("r3_holds", bus.readData1, 32'hAAAA);
        clock_edge();

        // fill the scoreboard, then asynchronous reset mid-cycle
        for (int r = 1; r < DEPTH; r++) begin
            drive(0, 0, '0, 1, r, r, 0);
            cycle();
        end
        drive(0, 0, '0, 0, 0, 1, 2);
        settle();
        check_eq("full_count", 32'(bus.busyCount), 32'd31);
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        check_eq("async_rst_count", 32'(bus.busyCount), 32'h0);
        for (int a = 0; a < DEPTH; a++) begin
            bus.readReg1 = ADDR_W'(a);
            bus.readReg2 = ADDR_W'(DEPTH - 1 - a);
            #0.1;
            check_eq("async_rst_rd1", bus.readData1, 32'h0);
            check_eq("async_rst_rd2", bus.readData2, 32'h0);
            check_eq("async_rst_busy1", 32'(bus.busy1), 32'h0);
            check_eq("async_rst_hazard", 32'(bus.hazard), 32'h0);
        end
        clock_edge();
        rst = 1'b0;

        // randomized traffic; a narrow address range raises collision rates
        for (int n = 0; n < 3000; n++) begin
            int lim;
            lim = (n < 1500) ? 7 : 31;
            drive(($urandom_range(0, 99) < 45), $urandom_range(0, lim), $urandom,
                  ($urandom_range(0, 99) < 50), $urandom_range(0, lim),
                  $urandom_range(0, lim), $urandom_range(0, lim));
            if ($urandom_range(0, 499) == 0) begin
                rst = 1'b1;
                model_reset();
            end else begin
                rst = 1'b0;
            end
            cycle();
        end
        rst = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
